grid_move_sched: RTL

- Controller that sequences the grid cursor datapath.
- Accepts move commands from two requesters, the rotary encoder and a push-button walker.
- Each requester raises an event strobe plus a 4-bit command; commands are queued in a small FIFO.
- An FSM replays each command as single-unit steps on the X/Y position registers, saturating at the grid edges, so the cursor visibly walks one cell per clock.

---
 rtl/grid_move_sched.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/grid_move_sched.sv
// -----------------------------------------------------------------------------
// grid_move_sched
//
// Sequences the grid cursor datapath. Two requesters (rotary encoder and
// push-button walker) raise an event strobe together with a 4-bit move
// command. Commands are taken on the strobe's rising edge and queued in a
// small FIFO. A two-state FSM replays each queued command as single-unit
// steps on the X/Y position registers, one cell per clock.
//
// Command encoding (rot_cmd / btn_cmd):
//   [3:2] step count 0..3
//   [1]   axis (0 = Y, 1 = X)
//   [0]   direction (0 = +, 1 = -)
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   rot_event  rotary strobe, a command is taken on its 0->1 transition
//   rot_cmd    rotary command
//   btn_event  button strobe, rising-edge qualified
//   btn_cmd    button command
//   pos_x      current X coordinate (0..MAX_COORD)
//   pos_y      current Y coordinate (0..MAX_COORD)
//   busy       FSM not idle or FIFO non-empty
//   fifo_full  FIFO holds FIFO_DEPTH entries
//   drop_cnt   commands dropped for lack of space, saturates at 255
//
// Build option:
//   GRID_WRAP_EN  when defined, a step at a grid edge wraps around
//                 (MAX_COORD+1 -> 0, 0-1 -> MAX_COORD) and every command
//                 completes all of its steps. When undefined, a step at a
//                 grid edge terminates the command early (saturation).
// -----------------------------------------------------------------------------
module grid_move_sched #(
   parameter int COORD_W    = 4,
   parameter int MAX_COORD  = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rot_event,
   input  logic [3:0]         rot_cmd,
   input  logic               btn_event,
   input  logic [3:0]         btn_cmd,
   output logic [COORD_W-1:0] pos_x,
   output logic [COORD_W-1:0] pos_y,
   output logic               busy,
   output logic               fifo_full,
   output logic [7:0]         drop_cnt
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int EXT_W = COORD_W + 1;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(MAX_COORD);

   typedef struct packed {
      logic [1:0] step;
      logic       axis;
      logic       dir;
   } cmd_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_STEP = 1'b1
   } state_t;

   // ---------------------------------------------------------------------------
   // Requester edge detection
   // ---------------------------------------------------------------------------
   // History resets to 1 so a strobe already high when reset releases is
   // not mistaken for a fresh request.
   logic rot_prev;
   logic btn_prev;
   logic rot_rise;
   logic btn_rise;

   assign rot_rise = rot_event & ~rot_prev;
   assign btn_rise = btn_event & ~btn_prev;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      if (rst) begin
         rot_prev <= 1'b1;
         btn_prev <= 1'b1;
      end else begin
         rot_prev <= rot_event;
         btn_prev <= btn_event;
      end
   end

   // ---------------------------------------------------------------------------
   // Command FIFO and arbitration
   // ---------------------------------------------------------------------------
   cmd_t             mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] wr_ptr_2nd;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             prio_btn;     // 0: rotary holds priority, 1: button

   state_t           state;
   logic             pop;
   cmd_t             head;

   logic             room_one;
   logic             room_two;
   logic [1:0]       push_num;
   logic [1:0]       drop_num;
   logic             prio_flip;
   cmd_t             wr_first;
   cmd_t             wr_second;
   logic [8:0]       drop_sum;

   // Room is judged on the occupancy at the start of the cycle; a pop in
   // the same cycle does not free a slot for an incoming command.
   assign room_one   = (count < DEPTH_C);
   assign room_two   = (count <= (DEPTH_C - CNT_W'(2)));
   assign wr_ptr_2nd = wr_ptr + PTR_W'(1);
   assign head       = mem[rd_ptr];
   assign pop        = (state == ST_IDLE) && (count != '0);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      push_num  = 2'd0;
      drop_num  = 2'd0;
      prio_flip = 1'b0;
      wr_first  = cmd_t'(rot_cmd);
      wr_second = cmd_t'(btn_cmd);

      if (rot_rise && btn_rise) begin
         // Simultaneous requests: priority holder goes first (older entry),
         // and priority alternates after every tie.
         prio_flip = 1'b1;
         wr_first  = prio_btn ? cmd_t'(btn_cmd) : cmd_t'(rot_cmd);
         wr_second = prio_btn ? cmd_t'(rot_cmd) : cmd_t'(btn_cmd);
         if (room_two) begin
            push_num = 2'd2;
         end else if (room_one) begin
            push_num = 2'd1;
            drop_num = 2'd1;
         end else begin
            drop_num = 2'd2;
         end
      end else if (rot_rise || btn_rise) begin
         wr_first = rot_rise ? cmd_t'(rot_cmd) : cmd_t'(btn_cmd);
         if (room_one) begin
            push_num = 2'd1;
         end else begin
            drop_num = 2'd1;
         end
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers and
   // occupancy count define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_num != 2'd0) begin
         mem[wr_ptr] <= wr_first;
      end
      if (push_num == 2'd2) begin
         mem[wr_ptr_2nd] <= wr_second;
      end
   end

   assign drop_sum = {1'b0, drop_cnt} + 9'(drop_num);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         prio_btn <= 1'b0;
         drop_cnt <= 8'd0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(push_num);
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push_num) - CNT_W'(pop);
         if (prio_flip) begin
            prio_btn <= ~prio_btn;
         end
         drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

   // ---------------------------------------------------------------------------
   // Step engine
   // ---------------------------------------------------------------------------
   logic               axis;
   logic               dir;
   logic [1:0]         remaining;

   logic [COORD_W-1:0] cur;
   logic [EXT_W-1:0]   cur_ext;
   logic [EXT_W-1:0]   next_ext;
   logic               at_bound;
   logic               stop_at_bound;

   // One extra bit of headroom keeps the +1/-1 arithmetic free of silent
   // wrap; the edge cases are selected explicitly so the result always
   // stays within 0..MAX_COORD.
   always_comb begin
      cur      = axis ? pos_x : pos_y;
      cur_ext  = {1'b0, cur};
      at_bound = dir ? (cur_ext == '0) : (cur_ext == MAX_EXT);
      if (dir) begin
         next_ext = at_bound ? MAX_EXT : (cur_ext - EXT_W'(1));
      end else begin
         next_ext = at_bound ? '0 : (cur_ext + EXT_W'(1));
      end
`ifdef GRID_WRAP_EN
      stop_at_bound = 1'b0;
`else
      stop_at_bound = at_bound;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         axis      <= 1'b0;
         dir       <= 1'b0;
         remaining <= 2'd0;
         pos_x     <= '0;
         pos_y     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  axis      <= head.axis;
                  dir       <= head.dir;
                  remaining <= head.step;
                  state     <= ST_STEP;
               end
            end
            ST_STEP: begin
               if (remaining == 2'd0) begin
                  state <= ST_IDLE;
               end else if (stop_at_bound) begin
                  // Edge reached: abandon the rest of the command.
                  remaining <= 2'd0;
                  state     <= ST_IDLE;
               end else begin
                  if (axis) begin
                     pos_x <= next_ext[COORD_W-1:0];
                  end else begin
                     pos_y <= next_ext[COORD_W-1:0];
                  end
                  remaining <= remaining - 2'd1;
                  if (remaining == 2'd1) begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = (state != ST_IDLE) || (count != '0);
   assign fifo_full = (count == DEPTH_C);

   // ---------------------------------------------------------------------------
   // Internal invariants
   // ---------------------------------------------------------------------------
   a_count_le_depth : assert property (@(posedge clk) disable iff (rst)
                                       count <= DEPTH_C);
   a_pos_x_in_range : assert property (@(posedge clk) disable iff (rst)
                                       pos_x <= COORD_W'(MAX_COORD));
   a_pos_y_in_range : assert property (@(posedge clk) disable iff (rst)
                                       pos_y <= COORD_W'(MAX_COORD));

endmodule
